// File: rtl/freq_sweep_pkg.sv
// Shared types and default widths for the Doppler frequency-sweep controller.
package freq_sweep_pkg;

  localparam int unsigned PHASE_BITS_DEF    = 32;
  localparam int unsigned BIN_BITS_DEF      = 8;
  localparam int unsigned LEN_BITS_DEF      = 16;
  localparam int unsigned SETTLE_CYCLES_DEF = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_RUN,
    S_DONE
  } sweep_state_t;

endpackage

// File: rtl/sweep_counter.sv
// Loadable up-counter with a terminal-count flag against a programmable last value.
module sweep_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  input  logic [WIDTH-1:0] last,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc) begin
      count <= count + WIDTH'(1);
    end
  end

  assign tc = (count == last);

endmodule

// File: rtl/freq_sweep_ctrl.sv
// Steps the sig_gen NCO across Doppler bins, flushing a settle window after each retune.
// Define FREQ_SWEEP_CONTINUOUS_EN for looping sweeps with a stop input.
module freq_sweep_ctrl
  import freq_sweep_pkg::*;
#(
  parameter int unsigned PHASE_BITS    = PHASE_BITS_DEF,
  parameter int unsigned BIN_BITS      = BIN_BITS_DEF,
  parameter int unsigned LEN_BITS      = LEN_BITS_DEF,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [PHASE_BITS-1:0] freq_start,
  input  logic [PHASE_BITS-1:0] freq_incr,
  input  logic [BIN_BITS-1:0]   num_bins,
  input  logic [LEN_BITS-1:0]   samples_per_bin,
  input  logic                  s_axis_data_tvalid,
  output logic [PHASE_BITS-1:0] freq_step,
  output logic                  m_axis_data_tready,
  output logic                  sample_keep,
  output logic [BIN_BITS-1:0]   bin_index,
  output logic                  bin_start,
  output logic                  bin_last,
  output logic                  busy,
  output logic                  done
`ifdef FREQ_SWEEP_CONTINUOUS_EN
  ,
  input  logic                  stop
`endif
);

  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  sweep_state_t          state;
  logic [PHASE_BITS-1:0] fs_q;
  logic [PHASE_BITS-1:0] fi_q;
  logic [BIN_BITS-1:0]   nb_q;
  logic [LEN_BITS-1:0]   spb_q;
  logic                  run_q;

  logic                  settle_tc;
  logic                  samp_tc;
  logic                  bin_tc;
  logic                  samp_final;
  logic                  wrap;
  logic                  pass_end;
  logic                  to_done;
  logic                  to_idle;
  logic [PHASE_BITS-1:0] next_freq;
  logic                  next_last;
  logic [SET_W-1:0]      settle_cnt_unused;
  logic [LEN_BITS-1:0]   samp_cnt_unused;

  // run_q mirrors state==RUN so the keep qualifier is a single flop ANDed with valid
  assign sample_keep = run_q & s_axis_data_tvalid;
  assign samp_final  = sample_keep & samp_tc;

`ifdef FREQ_SWEEP_CONTINUOUS_EN
  logic stop_q;
  logic halt;
  assign halt     = stop | stop_q;
  assign wrap     = bin_tc & ~halt;
  assign pass_end = bin_tc;
  assign to_done  = 1'b0;
  assign to_idle  = halt;
`else
  assign wrap     = 1'b0;
  assign pass_end = bin_tc;
  assign to_done  = bin_tc;
  assign to_idle  = 1'b0;
`endif

  assign next_freq = wrap ? fs_q : (freq_step + fi_q);
  assign next_last = wrap ? (nb_q == BIN_BITS'(1))
                          : ((bin_index + BIN_BITS'(1)) == (nb_q - BIN_BITS'(1)));

  sweep_counter #(.WIDTH(SET_W)) u_settle_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (state != S_SETTLE),
    .load_val ('0),
    .inc      (state == S_SETTLE),
    .last     (SET_W'(SETTLE_CYCLES - 1)),
    .count    (settle_cnt_unused),
    .tc       (settle_tc)
  );

  // spb_q - 1 wraps to all-ones when samples_per_bin is 0, giving a full 2^LEN_BITS bin
  sweep_counter #(.WIDTH(LEN_BITS)) u_samp_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (~run_q | samp_final),
    .load_val ('0),
    .inc      (sample_keep),
    .last     (spb_q - LEN_BITS'(1)),
    .count    (samp_cnt_unused),
    .tc       (samp_tc)
  );

  sweep_counter #(.WIDTH(BIN_BITS)) u_bin_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     ((state == S_LOAD) | (samp_final & wrap)),
    .load_val ('0),
    .inc      (samp_final & ~bin_tc),
    .last     (nb_q - BIN_BITS'(1)),
    .count    (bin_index),
    .tc       (bin_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= S_IDLE;
      fs_q               <= '0;
      fi_q               <= '0;
      nb_q               <= '0;
      spb_q              <= '0;
      freq_step          <= '0;
      m_axis_data_tready <= 1'b0;
      run_q              <= 1'b0;
      bin_start          <= 1'b0;
      bin_last           <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
`ifdef FREQ_SWEEP_CONTINUOUS_EN
      stop_q             <= 1'b0;
`endif
    end else begin
      bin_start <= 1'b0;
      done      <= 1'b0;
`ifdef FREQ_SWEEP_CONTINUOUS_EN
      if (state == S_IDLE) begin
        stop_q <= 1'b0;
      end else if (stop) begin
        stop_q <= 1'b1;
      end
`endif
      unique case (state)
        S_IDLE: begin
          if (start) begin
            fs_q  <= freq_start;
            fi_q  <= freq_incr;
            nb_q  <= num_bins;
            spb_q <= samples_per_bin;
            busy  <= 1'b1;
            if (num_bins == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          freq_step          <= fs_q;
          m_axis_data_tready <= 1'b1;
          bin_last           <= (nb_q == BIN_BITS'(1));
          if (SETTLE_CYCLES == 0) begin
            state     <= S_RUN;
            run_q     <= 1'b1;
            bin_start <= 1'b1;
          end else begin
            state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_tc) begin
            state     <= S_RUN;
            run_q     <= 1'b1;
            bin_start <= 1'b1;
          end
        end
        S_RUN: begin
          if (samp_final) begin
            done <= pass_end;
            if (to_done || to_idle) begin
              state              <= to_done ? S_DONE : S_IDLE;
              busy               <= to_done;
              m_axis_data_tready <= 1'b0;
              run_q              <= 1'b0;
              bin_last           <= 1'b0;
            end else begin
              freq_step <= next_freq;
              bin_last  <= next_last;
              if (SETTLE_CYCLES == 0) begin
                bin_start <= 1'b1;
              end else begin
                state <= S_SETTLE;
                run_q <= 1'b0;
              end
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Directed table-driven bench for freq_sweep_ctrl (SETTLE_CYCLES = 2, single-sweep build).
module tb_freq_sweep_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] freq_start = '0;
  logic [31:0] freq_incr = '0;
  logic [7:0]  num_bins = '0;
  logic [15:0] samples_per_bin = '0;
  logic        s_axis_data_tvalid = 1'b0;
  logic [31:0] freq_step;
  logic        m_axis_data_tready;
  logic        sample_keep;
  logic [7:0]  bin_index;
  logic        bin_start;
  logic        bin_last;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  freq_sweep_ctrl #(
    .PHASE_BITS    (32),
    .BIN_BITS      (8),
    .LEN_BITS      (16),
    .SETTLE_CYCLES (2)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .freq_start         (freq_start),
    .freq_incr          (freq_incr),
    .num_bins           (num_bins),
    .samples_per_bin    (samples_per_bin),
    .s_axis_data_tvalid (s_axis_data_tvalid),
    .freq_step          (freq_step),
    .m_axis_data_tready (m_axis_data_tready),
    .sample_keep        (sample_keep),
    .bin_index          (bin_index),
    .bin_start          (bin_start),
    .bin_last           (bin_last),
    .busy               (busy),
    .done               (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] fs;
    logic [31:0] fi;
    logic [7:0]  nb;
    logic [15:0] spb;
    bit          toggle;   // valid high on odd cycles only
    bit          poke;     // restart attempt plus config change mid-sweep
    logic [31:0] f0;
    logic [31:0] f1;
    logic [31:0] f2;
    int          starts;
    int          keep;     // kept samples per bin
    int          disc;     // valid cycles flushed while tready
    int          done_cyc; // cycles after the start edge
    int          run_cyc;  // cycle of the first bin_start
    int          bl;       // cycles with bin_last high
    bit          tr;       // tready ever high
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_sweep(input vec_t v, input int id);
    logic [31:0] fr[3];
    logic [31:0] fexp[3];
    int keeps[3];
    int starts = 0;
    int disc = 0;
    int done_cyc = -1;
    int run_cyc = 0;
    int bl = 0;
    int cyc = 0;
    bit tr = 1'b0;
    bit fin = 1'b0;
    fexp[0] = v.f0;
    fexp[1] = v.f1;
    fexp[2] = v.f2;
    for (int i = 0; i < 3; i++) begin
      fr[i] = '0;
      keeps[i] = 0;
    end
    @(negedge clk);
    freq_start      = v.fs;
    freq_incr       = v.fi;
    num_bins        = v.nb;
    samples_per_bin = v.spb;
    s_axis_data_tvalid = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (!fin && cyc < 200) begin
      cyc++;
      s_axis_data_tvalid = v.toggle ? cyc[0] : 1'b1;
      if (v.poke && cyc == 6) begin
        start           = 1'b1;
        num_bins        = 8'd0;
        freq_start      = 32'hDEAD_BEEF;
        freq_incr       = 32'd1;
        samples_per_bin = 16'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (bin_start) begin
        chk($sformatf("v%0d_bin_index_at_start%0d", id, starts), bin_index, starts);
        if (starts < 3) fr[starts] = freq_step;
        if (starts == 0) run_cyc = cyc;
        starts++;
      end
      if (sample_keep && bin_index < 8'd3) keeps[bin_index]++;
      if (m_axis_data_tready && s_axis_data_tvalid && !sample_keep) disc++;
      if (m_axis_data_tready) tr = 1'b1;
      if (bin_last) bl++;
      if (done) begin
        done_cyc = cyc;
        fin = 1'b1;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    start = 1'b0;
    chk($sformatf("v%0d_done_seen", id), fin, 1'b1);
    chk($sformatf("v%0d_done_cycle", id), done_cyc, v.done_cyc);
    chk($sformatf("v%0d_bin_starts", id), starts, v.starts);
    chk($sformatf("v%0d_first_run_cycle", id), run_cyc, v.run_cyc);
    chk($sformatf("v%0d_settle_discards", id), disc, v.disc);
    chk($sformatf("v%0d_tready_seen", id), tr, v.tr);
    chk($sformatf("v%0d_bin_last_cycles", id), bl, v.bl);
    for (int i = 0; i < int'(v.nb) && i < 3; i++) begin
      chk($sformatf("v%0d_freq_bin%0d", id, i), fr[i], fexp[i]);
      chk($sformatf("v%0d_keeps_bin%0d", id, i), keeps[i], v.keep);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    chk($sformatf("v%0d_idle_after_done", id), {busy, m_axis_data_tready, done, bin_last}, 4'b0000);
  endtask

  initial begin
    int dn;
    bit reached;
    tbl[0] = '{32'd100, 32'd50, 8'd3, 16'd4, 1'b0, 1'b0,
               32'd100, 32'd150, 32'd200, 3, 4, 6, 20, 4, 6, 1'b1};
    tbl[1] = '{32'hFFFF_FED4, 32'd200, 8'd2, 16'd4, 1'b1, 1'b0,
               32'hFFFF_FED4, 32'hFFFF_FF9C, 32'd0, 2, 4, 2, 22, 4, 10, 1'b1};
    tbl[2] = '{32'hFFFF_FFF0, 32'h20, 8'd2, 16'd1, 1'b0, 1'b0,
               32'hFFFF_FFF0, 32'h0000_0010, 32'd0, 2, 1, 4, 8, 4, 3, 1'b1};
    tbl[3] = '{32'd5, 32'd5, 8'd0, 16'd4, 1'b0, 1'b0,
               32'd0, 32'd0, 32'd0, 0, 0, 0, 1, 0, 0, 1'b0};
    tbl[4] = '{32'h7FFF_FFFF, 32'd1, 8'd1, 16'd2, 1'b0, 1'b0,
               32'h7FFF_FFFF, 32'd0, 32'd0, 1, 2, 2, 6, 4, 4, 1'b1};
    tbl[5] = '{32'd100, 32'd50, 8'd3, 16'd4, 1'b0, 1'b1,
               32'd100, 32'd150, 32'd200, 3, 4, 6, 20, 4, 6, 1'b1};

    #12;
    chk("reset_freq_step", freq_step, 32'd0);
    chk("reset_bin_index", bin_index, 8'd0);
    chk("reset_ctl", {m_axis_data_tready, sample_keep, bin_start, bin_last, busy, done}, 6'b0);
    @(negedge clk);
    reset = 1'b0;

    for (int t = 0; t < 6; t++) begin
      run_sweep(tbl[t], t);
    end

    // Reset while bin 1 is running: everything clears at once, no done follows.
    @(negedge clk);
    freq_start = 32'd100;
    freq_incr = 32'd50;
    num_bins = 8'd3;
    samples_per_bin = 16'd4;
    s_axis_data_tvalid = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bin_index == 8'd1 && sample_keep) begin
        reached = 1'b1;
        break;
      end
    end
    chk("rst_mid_reached_bin1", reached, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_freq_step", freq_step, 32'd0);
    chk("rst_mid_bin_index", bin_index, 8'd0);
    chk("rst_mid_ctl", {m_axis_data_tready, sample_keep, bin_start, bin_last, busy, done}, 6'b0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    dn = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("rst_mid_no_done", dn, 0);
    chk("rst_mid_idle", {busy, m_axis_data_tready}, 2'b00);
    run_sweep(tbl[0], 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/freq_sweep_ctrl.md
# freq_sweep_ctrl

Sequences the `sig_gen` NCO across a programmed set of Doppler frequency bins for the CAF search. It drives `sig_gen`'s `freq_step` and `m_axis_data_tready`, and holds each bin for a fixed number of accepted samples. It flushes generator output during a settle window after every retune and qualifies the valid samples for the downstream correlator. It sits between the CAF top-level control and `sig_gen`.

## Interface
- `PHASE_BITS`, 32: phase-increment width; matches `sig_gen` `phase_bits`.
- `BIN_BITS`, 8: width of bin count and bin index.
- `LEN_BITS`, 16: width of samples-per-bin count.
- `SETTLE_CYCLES`, 2: cycles of generator output discarded after each retune. 0 is legal.

- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  one-cycle request to begin a sweep; ignored unless IDLE.
- `freq_start`  in  PHASE_BITS  phase increment of bin 0, two's complement.
- `freq_incr`  in  PHASE_BITS  phase-increment delta between bins, two's complement.
- `num_bins`  in  BIN_BITS  number of bins.
- `samples_per_bin`  in  LEN_BITS  accepted samples per bin.
- `s_axis_data_tvalid`  in  1  valid from `sig_gen`.
- `freq_step`  out  PHASE_BITS  to `sig_gen`.
- `m_axis_data_tready`  out  1  to `sig_gen`.
- `sample_keep`  out  1  the current `sig_gen` sample belongs to `bin_index`.
- `bin_index`  out  BIN_BITS  current bin.
- `bin_start`  out  1  one-cycle pulse on the first RUN cycle of each bin.
- `bin_last`  out  1  high while the final bin is active.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse at sweep completion.

## Operation
- **Config latch:** `freq_start`, `freq_incr`, `num_bins` and `samples_per_bin` are latched on the accepted `start`. Later input changes have no effect until the next sweep.
- **States:** IDLE, LOAD, SETTLE, RUN, DONE.
- **IDLE:**
  - With `start` = 1 and `num_bins` = 0: go to DONE.
  - With `start` = 1 otherwise: go to LOAD.
- **LOAD:** `freq_step` <= `freq_start`, `bin_index` <= 0, sample count cleared. Next state is SETTLE, or RUN if `SETTLE_CYCLES` = 0.
- **SETTLE:** `m_axis_data_tready` = 1. Counts `SETTLE_CYCLES` clock cycles regardless of valid. `sample_keep` = 0. Then go to RUN.
- **RUN:**
  - `m_axis_data_tready` = 1 and `sample_keep` = `s_axis_data_tvalid`.
  - Each kept sample increments the sample count.
  - On the kept sample where count = `samples_per_bin` - 1, with the last bin active: go to DONE.
  - On that sample otherwise: `freq_step` += `freq_incr`, `bin_index` += 1, clear count, go to SETTLE (or stay in RUN with `bin_start` if `SETTLE_CYCLES` = 0).
- **DONE:** `done` = 1 for one cycle, then IDLE.
- **Frequency arithmetic:** `freq_step` accumulates modulo 2^PHASE_BITS, with silent wrap. Negative Doppler bins come from a negative `freq_start`.
- **`samples_per_bin` = 0:** treated as 2^LEN_BITS samples.
- **`bin_last`:** equals (`bin_index` == latched `num_bins` - 1) while in SETTLE or RUN, else 0.

## Timing
- **Reset values:** `freq_step` 0, `m_axis_data_tready` 0, `sample_keep` 0, `bin_index` 0, `bin_start` 0, `bin_last` 0, `busy` 0, `done` 0. State is IDLE.
- **Mid-sweep reset:** an asserted `reset` returns everything to these values immediately. No `done` is produced.
- **Start latency:** `start` at edge N puts LOAD at N+1. The first SETTLE cycle is N+2. The first RUN cycle, with `bin_start`, is N+2+`SETTLE_CYCLES`.
- **Retune:** the new `freq_step` is registered on the edge that accepts the final sample of the previous bin.
- **Output type:** `sample_keep` is combinational from `s_axis_data_tvalid` and a registered state bit. All other outputs are registered.
- **Bin length:** one bin lasts exactly `samples_per_bin` kept samples. Gaps in valid stretch RUN, with no sample loss.
- **`start` during busy:** ignored, with no queuing.

## Configuration
- **`FREQ_SWEEP_CONTINUOUS_EN` defined:**
  - Completing the last bin returns to bin 0 (reload `freq_start`, go to SETTLE) instead of DONE, and pulses `done` each pass.
  - A `stop` input port (1 bit) is added. `stop` = 1 goes to IDLE at the next bin boundary.
  - `num_bins` = 0 still goes straight to DONE, then IDLE.
- **Undefined:** single sweep only, and no `stop` port.

## Structure
- **Package `freq_sweep_pkg`:** state enum `sweep_state_t`, default widths `PHASE_BITS_DEF`, `BIN_BITS_DEF` and `LEN_BITS_DEF`, and `SETTLE_CYCLES_DEF`.
- **Sub-module `sweep_counter`:** a loadable up-counter with terminal-count flag. It is instantiated for the settle, sample and bin counts.

## Test plan
- **Basic sweep:** `freq_start`=100, `freq_incr`=50, `num_bins`=3, `samples_per_bin`=4, valid constant.
  - `freq_step` sequence is 100, 150, 200.
  - 12 `sample_keep`, 3 `bin_start`, `done` at the end.
- **Settle discard:** `SETTLE_CYCLES`=2 → exactly 2 valid cycles with `sample_keep`=0 after each retune, including bin 0.
- **Valid gaps:** toggle valid 1/0 → each bin still yields exactly 4 kept samples.
- **Wrap:** `freq_start`=0xFFFFFFF0, `freq_incr`=0x20, 2 bins → bin 1 `freq_step`=0x00000010.
- **Degenerate:** `num_bins`=0 → `done` at N+1 with `m_axis_data_tready` never high; `start` while busy → ignored.
- **Reset mid-bin:** assert `reset` in bin 1 → all outputs at reset values the same cycle, no `done`; a fresh `start` then restarts at bin 0.
